// File: rtl/impl_monitor.sv
// Synthesizable monitor for "ante |=> cons" resolved DELAY clocks after the attempt.
// Counts attempts, passes and failures; latches the cycle index of the first failure.
module impl_monitor #(
    parameter int DELAY = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             ante,
    input  logic             cons,
    output logic             pass,
    output logic             fail,
    output logic             fail_seen,
    output logic             pending,
    output logic [CNT_W-1:0] att_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] first_fail
);

    if (DELAY < 1 || DELAY > 8) begin : g_bad_delay
        $error("impl_monitor: DELAY=%0d outside legal range 1..8", DELAY);
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DELAY-1:0] pipe_q, pipe_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             fail_seen_q, fail_seen_d;
    logic [CNT_W-1:0] att_cnt_q, att_cnt_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] first_fail_q, first_fail_d;

    logic start;
    logic resolve;

    assign start   = en & ante;
    assign resolve = pipe_q[DELAY-1];

    always_comb begin
        pipe_d       = pipe_q << 1;
        pipe_d[0]    = start;
        pass_d       = 1'b0;
        fail_d       = 1'b0;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        att_cnt_d    = att_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        cyc_cnt_d    = cyc_cnt_q + CNT_W'(1);

        if (start && att_cnt_q != CNT_MAX) begin
            att_cnt_d = att_cnt_q + CNT_W'(1);
        end

        if (resolve) begin
            if (cons) begin
                pass_d = 1'b1;
                if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end else begin
                fail_d      = 1'b1;
                fail_seen_d = 1'b1;
                if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
                // first_fail records the index held before this edge's increment
                if (!fail_seen_q) first_fail_d = cyc_cnt_q;
            end
        end

        // clr wins over everything at this edge except the free-running cycle index
        if (clr) begin
            pipe_d       = '0;
            pass_d       = 1'b0;
            fail_d       = 1'b0;
            fail_seen_d  = 1'b0;
            first_fail_d = '0;
            att_cnt_d    = '0;
            pass_cnt_d   = '0;
            fail_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q       <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
            att_cnt_q    <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            cyc_cnt_q    <= '0;
        end else begin
            pipe_q       <= pipe_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
            att_cnt_q    <= att_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
        end
    end

    assign pass       = pass_q;
    assign fail       = fail_q;
    assign fail_seen  = fail_seen_q;
    assign pending    = |pipe_q;
    assign att_cnt    = att_cnt_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign cyc_cnt    = cyc_cnt_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_impl_monitor.sv
// Directed bench for impl_monitor: three instances cover DELAY=1, DELAY=3 and a 4-bit counter build.
// Inputs change on the falling edge; outputs are sampled on the falling edge before new inputs.
module tb_impl_monitor;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // instance a: DELAY=1, CNT_W=16
    logic rst_a, en_a, clr_a, ante_a, cons_a;
    logic pass_a, fail_a, fseen_a, pend_a;
    logic [15:0] att_a, pcnt_a, fcnt_a, cyc_a, ff_a;
    // instance b: DELAY=3, CNT_W=16
    logic rst_b, en_b, clr_b, ante_b, cons_b;
    logic pass_b, fail_b, fseen_b, pend_b;
    logic [15:0] att_b, pcnt_b, fcnt_b, cyc_b, ff_b;
    // instance c: DELAY=1, CNT_W=4
    logic rst_c, en_c, clr_c, ante_c, cons_c;
    logic pass_c, fail_c, fseen_c, pend_c;
    logic [3:0] att_c, pcnt_c, fcnt_c, cyc_c, ff_c;

    impl_monitor #(.DELAY(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_a), .en(en_a), .clr(clr_a), .ante(ante_a), .cons(cons_a),
        .pass(pass_a), .fail(fail_a), .fail_seen(fseen_a), .pending(pend_a),
        .att_cnt(att_a), .pass_cnt(pcnt_a), .fail_cnt(fcnt_a), .cyc_cnt(cyc_a), .first_fail(ff_a)
    );

    impl_monitor #(.DELAY(3), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_b), .en(en_b), .clr(clr_b), .ante(ante_b), .cons(cons_b),
        .pass(pass_b), .fail(fail_b), .fail_seen(fseen_b), .pending(pend_b),
        .att_cnt(att_b), .pass_cnt(pcnt_b), .fail_cnt(fcnt_b), .cyc_cnt(cyc_b), .first_fail(ff_b)
    );

    impl_monitor #(.DELAY(1), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_c), .en(en_c), .clr(clr_c), .ante(ante_c), .cons(cons_c),
        .pass(pass_c), .fail(fail_c), .fail_seen(fseen_c), .pending(pend_c),
        .att_cnt(att_c), .pass_cnt(pcnt_c), .fail_cnt(fcnt_c), .cyc_cnt(cyc_c), .first_fail(ff_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b1; clr_a = 1'b0; ante_a = 1'b0; cons_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b1; clr_b = 1'b0; ante_b = 1'b0; cons_b = 1'b0;
        rst_c = 1'b0; en_c = 1'b1; clr_c = 1'b0; ante_c = 1'b0; cons_c = 1'b0;

        // reset state
        #10;
        chk("rst_att", att_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_fail", fail_a, 0);
        chk("rst_fseen", fseen_a, 0);
        chk("rst_pend", pend_a, 0);
        chk("rst_cyc", cyc_a, 0);
        chk("rst_ff", ff_a, 0);
        #30 rst_a = 1'b1;

        // scenario 1: (ante,cons) = (1,0),(0,1),(1,1),(0,0) at t=100..400
        @(negedge clk); ante_a = 1'b1; cons_a = 1'b0;
        @(negedge clk);
        chk("s1_pend", pend_a, 1);
        chk("s1_att1", att_a, 1);
        chk("s1_nopass", pass_a, 0);
        ante_a = 1'b0; cons_a = 1'b1;
        @(negedge clk);
        chk("s1_pass", pass_a, 1);
        chk("s1_pcnt1", pcnt_a, 1);
        ante_a = 1'b1; cons_a = 1'b1;
        @(negedge clk);
        chk("s1_pass_low", pass_a, 0);
        chk("s1_att2", att_a, 2);
        ante_a = 1'b0; cons_a = 1'b0;
        @(negedge clk);
        chk("s1_fail", fail_a, 1);
        chk("s1_pass_off", pass_a, 0);
        chk("s1_att", att_a, 2);
        chk("s1_pcnt", pcnt_a, 1);
        chk("s1_fcnt", fcnt_a, 1);
        chk("s1_fseen", fseen_a, 1);
        chk("s1_ff", ff_a, 4);
        chk("s1_pend0", pend_a, 0);
        clr_a = 1'b1; cons_a = 1'b1;

        // scenario 2: clear, then five back-to-back passing attempts
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("clr_att", att_a, 0);
                chk("clr_pcnt", pcnt_a, 0);
                chk("clr_fcnt", fcnt_a, 0);
                chk("clr_fseen", fseen_a, 0);
                chk("clr_ff", ff_a, 0);
                chk("clr_cyc_kept", cyc_a, 6);
            end
            clr_a = 1'b0;
            chk("s2_pass", pass_a, (k >= 2 && k <= 6) ? 1 : 0);
            chk("s2_fail", fail_a, 0);
            ante_a = (k < 5);
        end
        chk("s2_pcnt", pcnt_a, 5);
        chk("s2_fcnt", fcnt_a, 0);
        chk("s2_att", att_a, 5);

        // scenario 4: en=0 blocks new attempts but not resolution; clr on resolving edge
        en_a = 1'b0; ante_a = 1'b1; cons_a = 1'b1;
        @(negedge clk);
        chk("s4_en0_att", att_a, 5);
        chk("s4_en0_pend", pend_a, 0);
        en_a = 1'b1;
        @(negedge clk);
        chk("s4_att6", att_a, 6);
        chk("s4_pend1", pend_a, 1);
        en_a = 1'b0;
        @(negedge clk);
        chk("s4_inflight_pass", pass_a, 1);
        chk("s4_pcnt6", pcnt_a, 6);
        chk("s4_att_hold", att_a, 6);
        en_a = 1'b1; cons_a = 1'b0;
        @(negedge clk);
        chk("s4_att7", att_a, 7);
        chk("s4_pend2", pend_a, 1);
        clr_a = 1'b1; ante_a = 1'b0;
        @(negedge clk);
        chk("s4_clr_nofail", fail_a, 0);
        chk("s4_clr_fseen", fseen_a, 0);
        chk("s4_clr_pend", pend_a, 0);
        chk("s4_clr_fcnt", fcnt_a, 0);
        chk("s4_clr_att", att_a, 0);
        clr_a = 1'b0;

        // scenario 3: DELAY=3, attempt at edge 0, cons=1 only at edge 3
        rst_b = 1'b1; ante_b = 1'b1; cons_b = 1'b0;
        @(negedge clk);
        chk("s3_pend", pend_b, 1);
        chk("s3_att", att_b, 1);
        ante_b = 1'b0;
        @(negedge clk);
        chk("s3_e1_pass", pass_b, 0);
        chk("s3_e1_fail", fail_b, 0);
        @(negedge clk);
        chk("s3_e2_pass", pass_b, 0);
        chk("s3_e2_fail", fail_b, 0);
        chk("s3_e2_pend", pend_b, 1);
        cons_b = 1'b1;
        @(negedge clk);
        chk("s3_e3_pass", pass_b, 1);
        chk("s3_e3_fail", fail_b, 0);
        chk("s3_e3_pcnt", pcnt_b, 1);
        chk("s3_e3_pend", pend_b, 0);
        cons_b = 1'b0;
        @(negedge clk);
        chk("s3_e4_pass", pass_b, 0);
        rst_b = 1'b0;
        #1;
        chk("s3_rst_pcnt", pcnt_b, 0);

        // scenario 3 repeat: cons=0 at edge 3
        @(negedge clk);
        rst_b = 1'b1; ante_b = 1'b1; cons_b = 1'b0;
        @(negedge clk); ante_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("s3r_fail", fail_b, 1);
        chk("s3r_pass", pass_b, 0);
        chk("s3r_fseen", fseen_b, 1);
        chk("s3r_ff", ff_b, 3);
        chk("s3r_fcnt", fcnt_b, 1);

        // scenario 5: CNT_W=4 saturation and cycle wrap
        rst_c = 1'b1; ante_c = 1'b1; cons_c = 1'b1;
        repeat (20) @(negedge clk);
        ante_c = 1'b0;
        repeat (2) @(negedge clk);
        chk("s5_pcnt_sat", pcnt_c, 15);
        chk("s5_att_sat", att_c, 15);
        chk("s5_fcnt", fcnt_c, 0);
        chk("s5_cyc_wrap", cyc_c, 6);

        // asynchronous reset while an attempt is in flight
        ante_c = 1'b1;
        @(negedge clk);
        chk("s5_pend", pend_c, 1);
        ante_c = 1'b0;
        #10 rst_c = 1'b0;
        #1;
        chk("s5_arst_pend", pend_c, 0);
        chk("s5_arst_pcnt", pcnt_c, 0);
        chk("s5_arst_att", att_c, 0);
        chk("s5_arst_cyc", cyc_c, 0);
        chk("s5_arst_pass", pass_c, 0);
        @(negedge clk);
        chk("s5_hold_cyc", cyc_c, 0);
        rst_c = 1'b1;
        @(negedge clk);
        chk("s5_rel_pass", pass_c, 0);
        chk("s5_rel_fail", fail_c, 0);
        chk("s5_rel_pcnt", pcnt_c, 0);
        chk("s5_rel_cyc", cyc_c, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
